// File: rtl/data_mem_ctrl.sv
// Data memory controller: byte/half/word loads and stores into internal synchronous RAM.
// Latency: stores take effect at the request edge; load data appears in RESP, one cycle after the request.
// Backpressure: stall is high for the single request cycle of a load; stores never stall.
//
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   rd_en, wr_en        - load / store request from the control path (store wins if both)
//   funct3              - 000 B, 001 H, 010 W, 100 BU, 101 HU (others behave as W)
//   addr, wdata         - byte address and store data (low byte/half used for B/H)
//   rdata               - extended load result, zero outside the RESP state
//   stall, misaligned   - hold request for pipeline / misaligned-access flag
// Build option: define MISALIGN_TRAP_EN to flag and suppress misaligned H/W accesses;
// otherwise the offending low address bits are forced to zero and misaligned stays 0.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter bit INIT_ZERO   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Storage is not touched by reset; contents survive it.
  logic [31:0] mem [DEPTH_WORDS] = '{default: INIT_WORD};

  state_e      state_q, state_d;
  logic [31:0] rd_word_q;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;   // 00 byte, 01 half, 1x word
  logic        uns_q, uns_d;

  // Request decode
  logic          size_b, size_h, size_w;
  logic          trap;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic          req_ok, wr_fire, rd_fire;
  logic [3:0]    be;
  logic [31:0]   wr_dat;
  logic          unused_addr;

  assign size_b = (funct3[1:0] == 2'b00);
  assign size_h = (funct3[1:0] == 2'b01);
  assign size_w = ~(size_b | size_h);
  assign idx    = addr[AW+1:2];
  assign unused_addr = ^addr[31:AW+2];

`ifdef MISALIGN_TRAP_EN
  assign trap = (size_h & addr[0]) | (size_w & (addr[1:0] != 2'b00));
  assign lane = addr[1:0];
`else
  assign trap = 1'b0;
  // Silently align: halfwords drop addr[0], words drop addr[1:0].
  assign lane = size_w ? 2'b00 : (size_h ? {addr[1], 1'b0} : addr[1:0]);
`endif

  // Requests are only accepted in IDLE and outside reset.
  assign req_ok  = (state_q == IDLE) && !rst && !trap;
  assign wr_fire = req_ok && wr_en;
  assign rd_fire = req_ok && rd_en && !wr_en;

  always_comb begin
    be     = 4'b0000;
    wr_dat = wdata;
    if (size_b) begin
      be     = 4'b0001 << lane;
      wr_dat = {4{wdata[7:0]}};
    end else if (size_h) begin
      be     = 4'b0011 << {lane[1], 1'b0};
      wr_dat = {2{wdata[15:0]}};
    end else begin
      be     = 4'b1111;
      wr_dat = wdata;
    end
  end

  // RAM write port and synchronous read port. A load one cycle after a
  // store to the same word sees the new data because the write lands first.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
    if (rd_fire) rd_word_q <= mem[idx];
  end

  // Load attributes captured alongside the read for extension in RESP.
  always_comb begin
    lane_d = lane_q;
    size_d = size_q;
    uns_d  = uns_q;
    if (rd_fire) begin
      lane_d = lane;
      size_d = funct3[1:0];
      uns_d  = funct3[2];
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
    lane_q <= lane_d;
    size_q <= size_d;
    uns_q  <= uns_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = rd_fire ? RESP : IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    rdata      = 32'h0000_0000;
    stall      = 1'b0;
    misaligned = 1'b0;
    sel_b      = rd_word_q[{lane_q, 3'b000} +: 8];
    sel_h      = rd_word_q[{lane_q[1], 4'b0000} +: 16];
    case (state_q)
      IDLE: begin
        stall      = rd_fire;
        misaligned = !rst && (rd_en || wr_en) && trap;
      end
      RESP: begin
        if (size_q == 2'b00)      rdata = uns_q ? {24'h0, sel_b} : {{24{sel_b[7]}}, sel_b};
        else if (size_q == 2'b01) rdata = uns_q ? {16'h0, sel_h} : {{16{sel_h[15]}}, sel_h};
        else                      rdata = rd_word_q;
      end
      default: ;
    endcase
  end

endmodule
